tff_reg_bank: RTL and testbench

- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit register bank with four run-time modes (hold, D-load, per-bit T-toggle, modulo up/down count).
- Provides true and complemented outputs, a registered wrap pulse and a registered change flag.
- Used as a general state element wherever the design needs toggle registers or small modulo counters.

---
 rtl/tff_reg_bank_if.sv | 25 ++
 rtl/tff_reg_bank.sv | 103 ++++++++++
 tb/tb_tff_reg_bank.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tff_reg_bank_if.sv
// tff_reg_bank_if -- bus bundle for tff_reg_bank.
//   master : drives mode, d, t, up (and clr); observes q, qbar, tc, changed
//   slave  : the register bank itself
// Optional macro TFF_SYNC_CLR_EN adds the synchronous clear line clr.
interface tff_reg_bank_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] t;
  logic             up;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             changed;
`ifdef TFF_SYNC_CLR_EN
  logic             clr;

  modport master (output mode, d, t, up, clr, input q, qbar, tc, changed);
  modport slave  (input mode, d, t, up, clr, output q, qbar, tc, changed);
`else
  modport master (output mode, d, t, up, input q, qbar, tc, changed);
  modport slave  (input mode, d, t, up, output q, qbar, tc, changed);
`endif
endinterface

// File: rtl/tff_reg_bank.sv
// tff_reg_bank -- WIDTH-bit register bank with hold / load / per-bit toggle /
// modulo up-down count modes.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (q <= RESET_VAL)
//   bus      tff_reg_bank_if.slave:
//              mode   00 hold, 01 load, 10 toggle, 11 count
//              d      load data, t per-bit toggle enables, up count direction
//              q/qbar register state and its complement
//              tc     one-cycle pulse after a count wrap
//              changed q took a different value on the previous edge
//              clr    (TFF_SYNC_CLR_EN only) synchronous clear to RESET_VAL
// Optional macro: TFF_SYNC_CLR_EN.
module tff_reg_bank #(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MOD       = 256,
  parameter longint unsigned RESET_VAL = 0
) (
  input logic          clk,
  input logic          rst_n,
  tff_reg_bank_if.slave bus
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_LOAD   = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  // A modulus of 2^WIDTH truncates to all-ones, so wrap detection stays uniform.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("tff_reg_bank: WIDTH must be 1..32");
    end
    if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
      $error("tff_reg_bank: MOD must be 2..2^WIDTH");
    end
    if (RESET_VAL >= MOD) begin : g_bad_rst
      $error("tff_reg_bank: RESET_VAL must be < MOD");
    end
  endgenerate

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_r;
  logic             tc_nxt;
  logic             changed_r;

  always_comb begin
    q_nxt  = q_r;
    tc_nxt = 1'b0;
    case (bus.mode)
      MODE_HOLD:   q_nxt = q_r;
      MODE_LOAD:   q_nxt = bus.d;
      MODE_TOGGLE: q_nxt = q_r ^ bus.t;
      MODE_COUNT: begin
        if (bus.up) begin
          // out-of-range values (from load/toggle) wrap to 0 like MOD-1 does
          if (q_r >= MAX_Q) begin
            q_nxt  = '0;
            tc_nxt = 1'b1;
          end else begin
            q_nxt = q_r + 1'b1;
          end
        end else begin
          if (q_r == '0 || q_r > MAX_Q) begin
            q_nxt  = MAX_Q;
            tc_nxt = 1'b1;
          end else begin
            q_nxt = q_r - 1'b1;
          end
        end
      end
      default: q_nxt = q_r;
    endcase
`ifdef TFF_SYNC_CLR_EN
    if (bus.clr) begin
      q_nxt  = RST_Q;
      tc_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= RST_Q;
      tc_r      <= 1'b0;
      changed_r <= 1'b0;
    end else begin
      q_r       <= q_nxt;
      tc_r      <= tc_nxt;
      changed_r <= (q_nxt != q_r);
    end
  end

  assign bus.q       = q_r;
  assign bus.qbar    = ~q_r;
  assign bus.tc      = tc_r;
  assign bus.changed = changed_r;

endmodule

// File: tb/tb_tff_reg_bank.sv
module tb_tff_reg_bank;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  tff_reg_bank_if #(.WIDTH(8)) bus_a ();
  tff_reg_bank_if #(.WIDTH(8)) bus_b ();

  tff_reg_bank #(.WIDTH(8), .MOD(256), .RESET_VAL(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  tff_reg_bank #(.WIDTH(8), .MOD(10), .RESET_VAL(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_a.mode = 2'b00; bus_a.d = 8'h00; bus_a.t = 8'h00; bus_a.up = 1'b1;
    bus_b.mode = 2'b00; bus_b.d = 8'h00; bus_b.t = 8'h00; bus_b.up = 1'b1;
`ifdef TFF_SYNC_CLR_EN
    bus_a.clr = 1'b0;
    bus_b.clr = 1'b0;
`endif

    // reset state
    tick(); tick();
    chk8("rst_q_a", bus_a.q, 8'h00);
    chk8("rst_qbar_a", bus_a.qbar, 8'hFF);
    chk1("rst_tc_a", bus_a.tc, 1'b0);
    chk1("rst_changed_a", bus_a.changed, 1'b0);
    chk8("rst_q_b", bus_b.q, 8'h00);
    rst_n = 1'b1;

    // count to 0x37, then async reset between edges
    bus_a.mode = 2'b01; bus_a.d = 8'h36;
    tick();
    chk8("pre_load_36", bus_a.q, 8'h36);
    bus_a.mode = 2'b11; bus_a.up = 1'b1;
    tick();
    chk8("count_37", bus_a.q, 8'h37);
    chk1("count_37_changed", bus_a.changed, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk8("async_rst_q", bus_a.q, 8'h00);
    chk8("async_rst_qbar", bus_a.qbar, 8'hFF);
    chk1("async_rst_tc", bus_a.tc, 1'b0);
    chk1("async_rst_changed", bus_a.changed, 1'b0);
    bus_a.mode = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    chk8("post_rst_hold", bus_a.q, 8'h00);

    // load / hold / toggle
    bus_a.mode = 2'b01; bus_a.d = 8'hA5;
    tick();
    chk8("load_a5_q", bus_a.q, 8'hA5);
    chk8("load_a5_qbar", bus_a.qbar, 8'h5A);
    chk1("load_a5_changed", bus_a.changed, 1'b1);
    chk1("load_a5_tc", bus_a.tc, 1'b0);
    bus_a.mode = 2'b00;
    tick();
    chk8("hold_q", bus_a.q, 8'hA5);
    chk1("hold_changed", bus_a.changed, 1'b0);
    bus_a.mode = 2'b10; bus_a.t = 8'h0F;
    tick();
    chk8("toggle_0f_q", bus_a.q, 8'hAA);
    chk1("toggle_0f_changed", bus_a.changed, 1'b1);
    bus_a.t = 8'h00;
    tick();
    chk8("toggle_00_q", bus_a.q, 8'hAA);
    chk1("toggle_00_changed", bus_a.changed, 1'b0);
    chk1("toggle_00_tc", bus_a.tc, 1'b0);

    // full 2^WIDTH modulus wraps
    bus_a.mode = 2'b01; bus_a.d = 8'hFE;
    tick();
    bus_a.mode = 2'b11; bus_a.up = 1'b1;
    tick();
    chk8("m256_up_ff", bus_a.q, 8'hFF);
    chk1("m256_up_ff_tc", bus_a.tc, 1'b0);
    tick();
    chk8("m256_wrap_q", bus_a.q, 8'h00);
    chk1("m256_wrap_tc", bus_a.tc, 1'b1);
    chk1("m256_wrap_changed", bus_a.changed, 1'b1);
    tick();
    chk8("m256_up_01", bus_a.q, 8'h01);
    chk1("m256_up_01_tc", bus_a.tc, 1'b0);
    bus_a.up = 1'b0;
    tick();
    chk8("m256_dn_00", bus_a.q, 8'h00);
    chk1("m256_dn_00_tc", bus_a.tc, 1'b0);
    tick();
    chk8("m256_dn_wrap_q", bus_a.q, 8'hFF);
    chk1("m256_dn_wrap_tc", bus_a.tc, 1'b1);
    bus_a.mode = 2'b00;

    // modulus 10: count up through the wrap
    bus_b.mode = 2'b01; bus_b.d = 8'd8;
    tick();
    bus_b.mode = 2'b11; bus_b.up = 1'b1;
    tick();
    chk8("m10_up_9", bus_b.q, 8'd9);
    chk1("m10_up_9_tc", bus_b.tc, 1'b0);
    tick();
    chk8("m10_up_0", bus_b.q, 8'd0);
    chk1("m10_up_0_tc", bus_b.tc, 1'b1);
    tick();
    chk8("m10_up_1", bus_b.q, 8'd1);
    chk1("m10_up_1_tc", bus_b.tc, 1'b0);

    // modulus 10: count down from 0, then a plain decrement
    bus_b.mode = 2'b01; bus_b.d = 8'd0;
    tick();
    bus_b.mode = 2'b11; bus_b.up = 1'b0;
    tick();
    chk8("m10_dn_wrap_q", bus_b.q, 8'd9);
    chk1("m10_dn_wrap_tc", bus_b.tc, 1'b1);
    tick();
    chk8("m10_dn_8", bus_b.q, 8'd8);
    chk1("m10_dn_8_tc", bus_b.tc, 1'b0);

    // out-of-range load then count either way
    bus_b.mode = 2'b01; bus_b.d = 8'd12;
    tick();
    chk8("m10_load_12", bus_b.q, 8'd12);
    chk1("m10_load_12_tc", bus_b.tc, 1'b0);
    bus_b.mode = 2'b11; bus_b.up = 1'b1;
    tick();
    chk8("m10_oor_up_q", bus_b.q, 8'd0);
    chk1("m10_oor_up_tc", bus_b.tc, 1'b1);
    bus_b.mode = 2'b01; bus_b.d = 8'd12;
    tick();
    bus_b.mode = 2'b11; bus_b.up = 1'b0;
    tick();
    chk8("m10_oor_dn_q", bus_b.q, 8'd9);
    chk1("m10_oor_dn_tc", bus_b.tc, 1'b1);

    // reset aborts a pending wrap: q=9 counting up, reset before the edge
    bus_b.up = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    chk8("abort_q", bus_b.q, 8'd0);
    chk1("abort_tc", bus_b.tc, 1'b0);
    bus_b.mode = 2'b00;
    rst_n = 1'b1;
    tick();
    chk1("abort_tc_after", bus_b.tc, 1'b0);
    chk8("abort_q_after", bus_b.q, 8'd0);

`ifdef TFF_SYNC_CLR_EN
    bus_a.mode = 2'b01; bus_a.d = 8'h33; bus_a.clr = 1'b0;
    tick();
    chk8("clr_pre_q", bus_a.q, 8'h33);
    bus_a.d = 8'h44; bus_a.clr = 1'b1;
    tick();
    chk8("clr_q", bus_a.q, 8'h00);
    chk1("clr_changed", bus_a.changed, 1'b1);
    chk1("clr_tc", bus_a.tc, 1'b0);
    tick();
    chk8("clr_again_q", bus_a.q, 8'h00);
    chk1("clr_again_changed", bus_a.changed, 1'b0);
    bus_a.clr = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
